// File: rtl/serial_101_pkg.sv
// Shared definitions for the serial "101" framing link (transmitter and detector side).
package serial_101_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE1A,
    PRE0,
    PRE1B,
    DATA,
    GAP
  } state_t;

  localparam logic [2:0] PREAMBLE     = 3'b101;
  localparam int         PREAMBLE_LEN = 3;

endpackage

// File: rtl/serial_101_framer_tx_if.sv
// Parallel word handshake into the framer: the producer offers data/valid, the framer answers ready.
interface serial_101_framer_tx_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/piso_shift_reg.sv
// Parallel-load, shift-left register presenting its MSB to the serial line.
module piso_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb,
  output logic             next_msb
);

  logic [WIDTH-1:0] shift_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      shift_reg <= '0;
    end else if (load) begin
      shift_reg <= din;
    end else if (shift) begin
      shift_reg <= shift_reg << 1;
    end
  end

  assign msb = shift_reg[WIDTH-1];

  // Bit that becomes the MSB after the next shift, so the line can be registered.
  generate
    if (WIDTH > 1) begin : g_wide
      assign next_msb = shift_reg[WIDTH-2];
    end else begin : g_one
      assign next_msb = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/serial_101_framer_tx.sv
// Serial framer: preamble 1,0,1, then the payload MSB first, then one guard 0.
module serial_101_framer_tx
  import serial_101_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   R,
  serial_101_framer_tx_if.slave  bus,
  output logic                   out,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] bit_idx_reg, bit_idx_next;
  logic             out_reg, out_next;
  logic             accept;
  logic             msb, next_msb;

  assign bus.ready  = (state_reg == IDLE) || (state_reg == GAP);
  assign accept     = bus.valid && bus.ready;
  assign busy       = (state_reg != IDLE);
  assign frame_done = (state_reg == GAP);
  assign out        = out_reg;

  piso_shift_reg #(.WIDTH(WIDTH)) u_piso (
    .clk      (clk),
    .srst     (R),
    .load     (accept),
    .shift    (state_reg == DATA),
    .din      (bus.data),
    .msb      (msb),
    .next_msb (next_msb)
  );

  always_comb begin
    state_next   = state_reg;
    bit_idx_next = bit_idx_reg;
    out_next     = 1'b0;

    case (state_reg)
      IDLE:  if (accept) state_next = PRE1A;
      PRE1A: state_next = PRE0;
      PRE0:  state_next = PRE1B;
      PRE1B: begin
        state_next   = DATA;
        bit_idx_next = LAST_IDX;
      end
      DATA: begin
        if (bit_idx_reg == '0) state_next = GAP;
        else                   bit_idx_next = bit_idx_reg - CNT_W'(1);
      end
      GAP:     state_next = accept ? PRE1A : IDLE;
      default: state_next = IDLE;
    endcase

    // Line value for the upcoming cycle; the shift register only moves while in DATA.
    case (state_next)
      PRE1A:   out_next = PREAMBLE[PREAMBLE_LEN-1];
      PRE0:    out_next = PREAMBLE[PREAMBLE_LEN-2];
      PRE1B:   out_next = PREAMBLE[0];
      DATA:    out_next = (state_reg == DATA) ? next_msb : msb;
      default: out_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (R) begin
      state_reg   <= IDLE;
      bit_idx_reg <= '0;
      out_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_idx_reg <= bit_idx_next;
      out_reg     <= out_next;
    end
  end

endmodule

// File: tb/tb_serial_101_framer_tx.sv
// Directed bench for the 101 framer (WIDTH=8 and WIDTH=1) with an expected-line scoreboard.
module tb_serial_101_framer_tx;

  typedef struct packed {
    logic o;
    logic b;
    logic f;
    logic r;
    logic p3;
  } exp_t;

  localparam exp_t IDLE_E = exp_t'(5'b0_0_0_1_0);

  logic clk = 1'b0;
  logic R;
  always #5 clk = ~clk;

  serial_101_framer_tx_if #(.WIDTH(8)) bus8 ();
  serial_101_framer_tx_if #(.WIDTH(1)) bus1 ();

  logic out8, busy8, fd8;
  logic out1, busy1, fd1;

  serial_101_framer_tx #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .R          (R),
    .bus        (bus8),
    .out        (out8),
    .busy       (busy8),
    .frame_done (fd8)
  );

  serial_101_framer_tx #(.WIDTH(1)) dut1 (
    .clk        (clk),
    .R          (R),
    .bus        (bus1),
    .out        (out1),
    .busy       (busy1),
    .frame_done (fd1)
  );

  exp_t       q8[$];
  exp_t       q1[$];
  int         passed  = 0;
  int         total   = 0;
  int         cyc     = 0;
  logic [2:0] hist    = 3'b000;
  bit         det_en  = 1'b0;
  int         det_cnt = 0;

  task automatic push8(input logic [7:0] d);
    q8.push_back(exp_t'(5'b1_1_0_0_0));
    q8.push_back(exp_t'(5'b0_1_0_0_0));
    q8.push_back(exp_t'(5'b1_1_0_0_1));
    for (int i = 7; i >= 0; i--) q8.push_back(exp_t'({d[i], 4'b1000}));
    q8.push_back(exp_t'(5'b0_1_1_1_0));
    $display("w8 frame queued data=%h", d);
  endtask

  task automatic push1(input logic d);
    q1.push_back(exp_t'(5'b1_1_0_0_0));
    q1.push_back(exp_t'(5'b0_1_0_0_0));
    q1.push_back(exp_t'(5'b1_1_0_0_1));
    q1.push_back(exp_t'({d, 4'b1000}));
    q1.push_back(exp_t'(5'b0_1_1_1_0));
    $display("w1 frame queued data=%b", d);
  endtask

  // One clock: sample #1 after the edge and compare both DUTs against the scoreboard.
  task automatic tick();
    exp_t       e8, e1;
    logic [3:0] a8, a1, w8, w1;
    logic       det;
    @(posedge clk);
    #1;
    cyc++;
    e8 = (q8.size() > 0) ? q8.pop_front() : IDLE_E;
    e1 = (q1.size() > 0) ? q1.pop_front() : IDLE_E;
    a8 = {out8, busy8, fd8, bus8.ready};
    a1 = {out1, busy1, fd1, bus1.ready};
    w8 = {e8.o, e8.b, e8.f, e8.r};
    w1 = {e1.o, e1.b, e1.f, e1.r};
    total++;
    assert (a8 === w8) passed++;
    else $error("FAIL w8_line cyc=%0d out/busy/done/ready got=%b want=%b", cyc, a8, w8);
    total++;
    assert (a1 === w1) passed++;
    else $error("FAIL w1_line cyc=%0d out/busy/done/ready got=%b want=%b", cyc, a1, w1);
    hist = {hist[1:0], out8};
    det  = (hist == 3'b101);
    if (det_en) begin
      if (det) det_cnt++;
      total++;
      assert (det === e8.p3) passed++;
      else $error("FAIL detect cyc=%0d got=%b want=%b", cyc, det, e8.p3);
    end
  endtask

  initial begin
    R          = 1'b1;
    bus8.valid = 1'b0;
    bus8.data  = 8'h00;
    bus1.valid = 1'b0;
    bus1.data  = 1'b0;

    // Reset state
    tick();
    tick();
    R = 1'b0;
    tick();

    // Single A5 frame, valid dropped after acceptance
    bus8.data  = 8'hA5;
    bus8.valid = 1'b1;
    push8(8'hA5);
    tick();
    bus8.valid = 1'b0;
    repeat (12) tick();

    // Back-to-back FF then 00 with valid held
    bus8.data  = 8'hFF;
    bus8.valid = 1'b1;
    push8(8'hFF);
    push8(8'h00);
    tick();
    bus8.data = 8'h00;
    repeat (11) tick();
    tick();
    bus8.valid = 1'b0;
    repeat (12) tick();

    // 3C frame with valid toggling and data churning mid-frame
    bus8.data  = 8'h3C;
    bus8.valid = 1'b1;
    push8(8'h3C);
    tick();
    for (int k = 1; k <= 10; k++) begin
      bus8.valid = k[0];
      bus8.data  = 8'($urandom);
      tick();
    end
    bus8.valid = 1'b0;
    tick();
    tick();

    // Reset at edge 5 of an A5 frame, then an 81 frame at edge 6
    bus8.data  = 8'hA5;
    bus8.valid = 1'b1;
    push8(8'hA5);
    tick();
    bus8.valid = 1'b0;
    repeat (4) tick();
    R = 1'b1;
    q8.delete();
    q1.delete();
    tick();
    R          = 1'b0;
    bus8.data  = 8'h81;
    bus8.valid = 1'b1;
    push8(8'h81);
    tick();
    bus8.valid = 1'b0;
    repeat (12) tick();

    // Loopback into an overlapping 101 detector: three 00 frames back-to-back
    bus8.data  = 8'h00;
    bus8.valid = 1'b1;
    push8(8'h00);
    push8(8'h00);
    push8(8'h00);
    det_cnt = 0;
    det_en  = 1'b1;
    tick();
    repeat (24) tick();
    bus8.valid = 1'b0;
    repeat (11) tick();
    tick();
    det_en = 1'b0;
    total++;
    assert (det_cnt == 3) passed++;
    else $error("FAIL detect_count got=%0d want=3", det_cnt);

    // WIDTH=1, data=1, valid held for two frames
    bus1.data  = 1'b1;
    bus1.valid = 1'b1;
    push1(1'b1);
    push1(1'b1);
    tick();
    repeat (5) tick();
    bus1.valid = 1'b0;
    repeat (5) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
